// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types and constants for the direct-mapped I-cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Controller states: lookup, line refill, and draining an abandoned request
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DRAIN  = 2'd2
    } icache_state_t;

    // addi x0, x0, 0 - handed to fetch whenever the lookup does not hit
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_ram
//  Description : Tag and data storage for the I-cache. Asynchronous read by
//                index/offset, synchronous single-word write; the tag is
//                written together with the last word of a line.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_line_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 22,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                clk,
    input  logic [$clog2(NUM_LINES)-1:0]        i_rd_idx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]   i_rd_ofs,
    output logic [DATA_WIDTH-1:0]               o_rd_data,
    output logic [TAG_WIDTH-1:0]                o_rd_tag,
    input  logic                                i_wr_en,
    input  logic                                i_wr_last,
    input  logic [$clog2(NUM_LINES)-1:0]        i_wr_idx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]   i_wr_ofs,
    input  logic [DATA_WIDTH-1:0]               i_wr_data,
    input  logic [TAG_WIDTH-1:0]                i_wr_tag
);

    logic [DATA_WIDTH-1:0] r_data [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_WIDTH-1:0]  r_tag  [NUM_LINES];

    // Refill writes one word per response; the tag lands with the final word
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_ofs] <= i_wr_data;
            if (i_wr_last) begin
                r_tag[i_wr_idx] <= i_wr_tag;
            end
        end
    end

    assign o_rd_data = r_data[i_rd_idx][i_rd_ofs];
    assign o_rd_tag  = r_tag[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
//  Module      : icache_direct
//  Description : Direct-mapped read-only instruction cache. Combinational hit
//                path to fetch; misses stall fetch and refill the line one
//                word at a time over a req/rvalid backing-memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_direct
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_rvalid_i
);

    localparam int c_OFS_B = $clog2(WORDS_PER_LINE);
    localparam int c_IDX_B = $clog2(NUM_LINES);
    localparam int c_TAG_B = ADDR_WIDTH - 2 - c_OFS_B - c_IDX_B;
    localparam logic [c_OFS_B-1:0] c_CNT_LAST = c_OFS_B'(WORDS_PER_LINE - 1);

    icache_state_t        r_state;
    icache_state_t        w_state_nxt;
    logic [NUM_LINES-1:0] r_valid;
    logic [c_OFS_B-1:0]   r_cnt;
    logic [c_TAG_B-1:0]   r_base_tag;
    logic [c_IDX_B-1:0]   r_base_idx;

    logic [c_OFS_B-1:0]    w_ofs;
    logic [c_IDX_B-1:0]    w_idx;
    logic [c_TAG_B-1:0]    w_tag;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [c_TAG_B-1:0]    w_rd_tag;
    logic                  w_hit;
    logic                  w_resp;
    logic                  w_last;
    logic                  w_fill_done;
    logic                  w_unused_addr;

    // PC split: word offset, line index, tag; byte-in-word bits carry no meaning
    assign w_ofs         = addr_i[2 +: c_OFS_B];
    assign w_idx         = addr_i[2 + c_OFS_B +: c_IDX_B];
    assign w_tag         = addr_i[ADDR_WIDTH-1 -: c_TAG_B];
    assign w_unused_addr = ^addr_i[1:0];

    icache_line_ram #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TAG_WIDTH      (c_TAG_B),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_ram (
        .clk       (clk),
        .i_rd_idx  (w_idx),
        .i_rd_ofs  (w_ofs),
        .o_rd_data (w_rd_data),
        .o_rd_tag  (w_rd_tag),
        .i_wr_en   (w_resp),
        .i_wr_last (w_last),
        .i_wr_idx  (r_base_idx),
        .i_wr_ofs  (r_cnt),
        .i_wr_data (mem_rdata_i),
        .i_wr_tag  (r_base_tag)
    );

    // Only IDLE may hit, so a line being refilled is never served half-written
    assign w_hit   = (r_state == IDLE) && r_valid[w_idx] && (w_rd_tag == w_tag);
    assign instr_o = w_hit ? w_rd_data : DATA_WIDTH'(NOP_INSTR);
    assign stall_o = ~w_hit;

    // A request is outstanding in every non-IDLE state
    assign mem_req_o  = (r_state != IDLE);
    assign mem_addr_o = {r_base_tag, r_base_idx, r_cnt, 2'b00};

    assign w_resp      = (r_state == REFILL) && mem_rvalid_i;
    assign w_last      = (r_cnt == c_CNT_LAST);
    assign w_fill_done = w_resp && w_last;

    // Next-state selection for the refill controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_hit && !flush_i) begin
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (flush_i) begin
                    // If the response arrives with the flush nothing is left
                    // outstanding, so there is nothing to drain.
                    w_state_nxt = mem_rvalid_i ? IDLE : DRAIN;
                end else if (w_fill_done) begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding request immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valid bits: flush wins over completing a line so a flushed fill never validates
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_valid <= '0;
        end else if (w_fill_done) begin
            r_valid[r_base_idx] <= 1'b1;
        end
    end

    // Word counter: cleared when a refill starts, advanced per response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && w_state_nxt == REFILL) begin
            r_cnt <= '0;
        end else if (w_resp) begin
            r_cnt <= r_cnt + c_OFS_B'(1);
        end
    end

    // Line address latch so a fetch redirect cannot retarget an active refill
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_state_nxt == REFILL) begin
            r_base_tag <= w_tag;
            r_base_idx <= w_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_direct
//  Description : Self-checking bench for icache_direct with a line-level
//                cache model and a read-only backing memory function.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: which line address (tag) each index currently holds
    bit          mv [64];
    logic [21:0] mt [64];

    always #5 clk = ~clk;

    icache_direct #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .NUM_LINES      (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .flush_i      (flush_i),
        .instr_o      (instr_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i)
    );

    // Backing memory contents: 0xA0 + word number, low region maps 0x0..0xC to 0xA0..0xA3
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) + 32'hA0) ^ (a & 32'hFFFF_FC00);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[9:4]] && (mt[a[9:4]] == a[31:10]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve a full line refill; optionally redirect the PC before word redir_word
    task automatic serve_refill(input logic [31:0] base, input int delay,
                                input int redir_word, input logic [31:0] redir_addr);
        for (int w = 0; w < 4; w++) begin
            logic [31:0] wa;
            wa = base + 32'(4 * w);
            if (w == redir_word) addr_i = redir_addr;
            for (int d = 0; d <= delay; d++) begin
                @(negedge clk);
                n_cmp++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== wa || stall_o !== 1'b1 || instr_o !== 32'h13) begin
                    n_fail++;
                    $display("FAIL refill_word: req=%b addr=%h stall=%b instr=%h, expected req=1 addr=%h stall=1 instr=00000013",
                             mem_req_o, mem_addr_o, stall_o, instr_o, wa);
                end
                if (d == delay) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_word(wa);
                end
                tick();
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = $urandom;
            end
        end
        mv[base[9:4]] = 1'b1;
        mt[base[9:4]] = base[31:10];
    endtask

    // One fetch: check hit/miss against the model, refill on a miss, then re-check
    task automatic lookup(input logic [31:0] a, input int delay);
        bit          h;
        logic [31:0] exp;
        addr_i = a;
        h      = model_hit(a);
        exp    = h ? mem_word({a[31:2], 2'b00}) : 32'h13;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== !h || instr_o !== exp || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lookup %h: stall=%b instr=%h req=%b, expected stall=%b instr=%h req=0",
                     a, stall_o, instr_o, mem_req_o, !h, exp);
        end
        tick();
        if (!h) begin
            serve_refill({a[31:4], 4'h0}, delay, -1, 32'h0);
            exp = mem_word({a[31:2], 2'b00});
            @(negedge clk);
            n_cmp++;
            if (stall_o !== 1'b0 || instr_o !== exp || mem_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL post_refill %h: stall=%b instr=%h req=%b, expected stall=0 instr=%h req=0",
                         a, stall_o, instr_o, mem_req_o, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; addr_i = 32'h0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b expected 1", stall_o); end
        n_cmp++;
        if (instr_o !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000013", instr_o); end
        n_cmp++;
        if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_miss_start: req=%b addr=%h expected req=1 addr=00000000", mem_req_o, mem_addr_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        lookup(32'h0, 1);
    endtask

    task automatic test_hit();
        lookup(32'h8, 1);
        lookup(32'h4, 1);
        lookup(32'hC, 1);
    endtask

    task automatic test_conflict();
        lookup(32'h400, 1);
        lookup(32'h0, 1);
        lookup(32'h404, 2);
    endtask

    task automatic test_flush_mid_refill();
        lookup(32'h0, 1);
        addr_i = 32'h20;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_miss: stall=%b expected 1", stall_o); end
        tick();
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            tick();
            @(negedge clk);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(32'h20 + 32'(4 * w));
            tick();
            mem_rvalid_i = 1'b0;
        end
        flush_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h28) begin
            n_fail++;
            $display("FAIL flush_cycle: req=%b addr=%h expected req=1 addr=00000028", mem_req_o, mem_addr_o);
        end
        tick();
        flush_i = 1'b0;
        model_clear();
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h28 || stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_hold: req=%b addr=%h stall=%b expected req=1 addr=00000028 stall=1",
                         mem_req_o, mem_addr_o, stall_o);
            end
            if (d == 2) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = $urandom;
            end
            tick();
            mem_rvalid_i = 1'b0;
        end
        lookup(32'h0, 1);
        lookup(32'h24, 1);
    endtask

    task automatic test_reset_mid_refill();
        addr_i = 32'h30;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_miss: stall=%b expected 1", stall_o); end
        tick();
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(32'h30);
        tick();
        mem_rvalid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %b expected 1", mem_req_o); end
        tick();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || instr_o !== 32'h13) begin
            n_fail++;
            $display("FAIL rstmid_after: req=%b stall=%b instr=%h expected req=0 stall=1 instr=00000013",
                     mem_req_o, stall_o, instr_o);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        tick();
        mem_rvalid_i = 1'b0;
        serve_refill(32'h30, 1, -1, 32'h0);
        lookup(32'h38, 1);
        lookup(32'h0, 1);
    endtask

    task automatic test_slow_redirect();
        addr_i = 32'h2040;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_pre_miss: stall=%b req=%b expected stall=1 req=0", stall_o, mem_req_o);
        end
        tick();
        serve_refill(32'h2040, 5, 2, 32'h3084);
        lookup(32'h3084, 2);
        lookup(32'h2048, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if (i % 12 == 11) begin
                addr_i  = a;
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                model_clear();
            end
            lookup(a, $urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_mid_refill();
        test_reset_mid_refill();
        test_slow_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
